// File: rtl/simmem_pkg.sv
// Shared types and default sizing for the simulated-memory response delay banks.
package simmem_pkg;

    localparam int RespDelayNumSlots  = 8;
    localparam int RespDelayWidth     = 8;
    localparam int RespDelayIdWidth   = 4;
    localparam int RespDelayDataWidth = 32;

    typedef logic [$clog2(RespDelayNumSlots)-1:0] slot_idx_t;

    // Slot layout at the default rdata/wresp bank widths.
    typedef struct packed {
        logic [RespDelayIdWidth-1:0]   id;
        logic [RespDelayDataWidth-1:0] data;
        logic [RespDelayWidth-1:0]     countdown;
    } resp_slot_t;

endpackage

// File: rtl/simmem_oldest_select.sv
// Picks the oldest requester under an age matrix (age_i[i][j]=1: j older than i).
module simmem_oldest_select #(
    parameter int N = 8
) (
    input  logic [N-1:0][N-1:0]     age_i,
    input  logic [N-1:0]            req_i,
    output logic [N-1:0]            grant_o,
    output logic [$clog2(N)-1:0]    idx_o
);

    localparam int IdxW = $clog2(N);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            // A requester wins when no other requester is older than it.
            grant_o[i] = req_i[i] && !(|(req_i & age_i[i]));
            if (grant_o[i]) begin
                idx_o = idx_o | IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/simmem_resp_delay_bank.sv
// Response delay store: per-entry countdown, same-ID ordering, oldest-first release.
// Optional stall counter port enabled by SIMMEM_RESP_DELAY_STALL_COUNT_EN.
module simmem_resp_delay_bank
    import simmem_pkg::*;
#(
    parameter int NumSlots   = RespDelayNumSlots,
    parameter int IDWidth    = RespDelayIdWidth,
    parameter int DataWidth  = RespDelayDataWidth,
    parameter int DelayWidth = RespDelayWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [IDWidth-1:0]            in_id_i,
    input  logic [DataWidth-1:0]          in_data_i,
    input  logic [DelayWidth-1:0]         in_delay_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [IDWidth-1:0]            out_id_o,
    output logic [DataWidth-1:0]          out_data_o,
    output logic [$clog2(NumSlots+1)-1:0] occupancy_o
`ifdef SIMMEM_RESP_DELAY_STALL_COUNT_EN
    ,
    output logic [15:0]                   stall_cycles_o
`endif
);

    localparam int IdxW = $clog2(NumSlots);
    localparam int OccW = $clog2(NumSlots + 1);

    typedef struct packed {
        logic [IDWidth-1:0]    id;
        logic [DataWidth-1:0]  data;
        logic [DelayWidth-1:0] countdown;
    } slot_t;

    slot_t                              slot_q [NumSlots];
    slot_t                              slot_d [NumSlots];
    logic [NumSlots-1:0]                valid_q, valid_d;
    logic [NumSlots-1:0][NumSlots-1:0]  age_q, age_d;
    logic                               out_valid_q, out_valid_d;
    logic [IdxW-1:0]                    lock_idx_q, lock_idx_d;
    logic [IDWidth-1:0]                 out_id_q, out_id_d;
    logic [DataWidth-1:0]               out_data_q, out_data_d;
    logic [OccW-1:0]                    occupancy_q, occupancy_d;

    logic                               accept, release_hs;
    logic [IdxW-1:0]                    alloc_idx;
    logic [NumSlots-1:0]                release_mask;
    logic [NumSlots-1:0]                eligible;
    logic [NumSlots-1:0][NumSlots-1:0]  head_grant;
    logic [IdxW-1:0]                    unused_head_idx [NumSlots];
    logic [NumSlots-1:0]                unused_sel_grant;
    logic [IdxW-1:0]                    sel_idx;

    // A slot may leave only when it is the oldest valid entry carrying its ID.
    for (genvar gi = 0; gi < NumSlots; gi++) begin : g_head
        logic [NumSlots-1:0] same_id;

        always_comb begin
            same_id = '0;
            for (int j = 0; j < NumSlots; j++) begin
                same_id[j] = valid_q[j] && (slot_q[j].id == slot_q[gi].id);
            end
        end

        simmem_oldest_select #(.N(NumSlots)) u_head (
            .age_i   (age_q),
            .req_i   (same_id),
            .grant_o (head_grant[gi]),
            .idx_o   (unused_head_idx[gi])
        );

        assign eligible[gi] = valid_q[gi] && (slot_q[gi].countdown == '0)
                              && (head_grant[gi] == (NumSlots'(1) << gi));
    end

    simmem_oldest_select #(.N(NumSlots)) u_sel (
        .age_i   (age_q),
        .req_i   (eligible),
        .grant_o (unused_sel_grant),
        .idx_o   (sel_idx)
    );

    assign in_ready_o = !(&valid_q);
    assign accept     = in_valid_i && in_ready_o;
    assign release_hs = out_valid_q && out_ready_i;

    always_comb begin
        alloc_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = IdxW'(i);
            end
        end
    end

    // NOTE: every variable gets its default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        valid_d      = valid_q;
        slot_d       = slot_q;
        age_d        = age_q;
        out_valid_d  = out_valid_q;
        lock_idx_d   = lock_idx_q;
        out_id_d     = out_id_q;
        out_data_d   = out_data_q;
        occupancy_d  = occupancy_q;
        release_mask = '0;

        for (int i = 0; i < NumSlots; i++) begin
            if (valid_q[i] && (slot_q[i].countdown != '0)) begin
                slot_d[i].countdown = slot_q[i].countdown - 1'b1;
            end
        end

        // The presented entry stays locked until its handshake; reselection waits a cycle.
        if (release_hs) begin
            valid_d[lock_idx_q]      = 1'b0;
            release_mask[lock_idx_q] = 1'b1;
            out_valid_d              = 1'b0;
        end else if (!out_valid_q && (|eligible)) begin
            out_valid_d = 1'b1;
            lock_idx_d  = sel_idx;
            out_id_d    = slot_q[sel_idx].id;
            out_data_d  = slot_q[sel_idx].data;
        end

        // Allocation uses registered validity, so a slot freed this edge is not reused yet.
        if (accept) begin
            valid_d[alloc_idx] = 1'b1;
            slot_d[alloc_idx]  = '{id: in_id_i, data: in_data_i, countdown: in_delay_i};
            for (int r = 0; r < NumSlots; r++) begin
                age_d[r][alloc_idx] = 1'b0;
            end
            age_d[alloc_idx] = valid_q & ~release_mask;
        end

        case ({accept, release_hs})
            2'b10:   occupancy_d = occupancy_q + OccW'(1);
            2'b01:   occupancy_d = occupancy_q - OccW'(1);
            default: occupancy_d = occupancy_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the slot store is flop-based and small, so it is cleared in full on reset.
            for (int i = 0; i < NumSlots; i++) begin
                slot_q[i] <= '0;
            end
            valid_q     <= '0;
            age_q       <= '0;
            out_valid_q <= 1'b0;
            lock_idx_q  <= '0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            occupancy_q <= '0;
        end else begin
            slot_q      <= slot_d;
            valid_q     <= valid_d;
            age_q       <= age_d;
            out_valid_q <= out_valid_d;
            lock_idx_q  <= lock_idx_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_id_o    = out_id_q;
    assign out_data_o  = out_data_q;
    assign occupancy_o = occupancy_q;

`ifdef SIMMEM_RESP_DELAY_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid_q && !out_ready_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_simmem_resp_delay_bank.sv
// Scoreboard bench for simmem_resp_delay_bank: directed traffic, decoupled output monitor.
module tb_simmem_resp_delay_bank;

    localparam int NumSlots   = 8;
    localparam int IDWidth    = 4;
    localparam int DataWidth  = 32;
    localparam int DelayWidth = 8;

    typedef struct {
        logic [IDWidth-1:0]   id;
        logic [DataWidth-1:0] data;
    } exp_item_t;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   in_valid_i = 1'b0;
    logic                   in_ready_o;
    logic [IDWidth-1:0]     in_id_i = '0;
    logic [DataWidth-1:0]   in_data_i = '0;
    logic [DelayWidth-1:0]  in_delay_i = '0;
    logic                   out_valid_o;
    logic                   out_ready_i = 1'b0;
    logic [IDWidth-1:0]     out_id_o;
    logic [DataWidth-1:0]   out_data_o;
    logic [3:0]             occupancy_o;
`ifdef SIMMEM_RESP_DELAY_STALL_COUNT_EN
    logic [15:0]            stall_cycles_o;
`endif

    int checks = 0;
    int errors = 0;
    exp_item_t exp_q [$];

    simmem_resp_delay_bank #(
        .NumSlots   (NumSlots),
        .IDWidth    (IDWidth),
        .DataWidth  (DataWidth),
        .DelayWidth (DelayWidth)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_id_i     (in_id_i),
        .in_data_i   (in_data_i),
        .in_delay_i  (in_delay_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_id_o    (out_id_o),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
`ifdef SIMMEM_RESP_DELAY_STALL_COUNT_EN
        ,
        .stall_cycles_o (stall_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_out(input logic [IDWidth-1:0] id, input logic [DataWidth-1:0] data);
        exp_item_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [IDWidth-1:0] id, input logic [DataWidth-1:0] data,
                        input logic [DelayWidth-1:0] delay);
        int waited = 0;
        while (!in_ready_o && waited < 100) begin
            tick();
            waited++;
        end
        check("send_ready_wait", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1;
        in_id_i    = id;
        in_data_i  = data;
        in_delay_i = delay;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid_o) && n < 300) begin
            tick();
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        check("drain_occupancy", 64'(occupancy_o), 64'd0);
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks AXI stability while stalled.
    initial begin
        exp_item_t e;
        bit prev_stall = 1'b0;
        logic [IDWidth-1:0] prev_id = '0;
        logic [DataWidth-1:0] prev_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", 64'(out_valid_o), 64'd1);
                    check("stall_id_held", 64'(out_id_o), 64'(prev_id));
                    check("stall_data_held", 64'(out_data_o), 64'(prev_data));
                end
                if (out_valid_o && out_ready_i) begin
                    check("sb_has_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("sb_out_id", 64'(out_id_o), 64'(e.id));
                        check("sb_out_data", 64'(out_data_o), 64'(e.data));
                    end
                end
                prev_stall = out_valid_o && !out_ready_i;
                prev_id    = out_id_o;
                prev_data  = out_data_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset values
        #1;
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_id", 64'(out_id_o), 64'd0);
        check("rst_out_data", 64'(out_data_o), 64'd0);
        check("rst_occupancy", 64'(occupancy_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Single response, delay 5: valid 6 cycles after accept
        out_ready_i = 1'b1;
        expect_out(4'd3, 32'hC0DE_0003);
        send(4'd3, 32'hC0DE_0003, 8'd5);
        cnt = 0;
        while (!out_valid_o && cnt < 40) begin
            tick();
            cnt++;
        end
        check("lat_d5_cycles", 64'(cnt), 64'd6);
        check("lat_d5_id", 64'(out_id_o), 64'd3);
        tick();
        tick();
        check("lat_d5_occ_after", 64'(occupancy_o), 64'd0);

        // Same ID: B (delay 0) must wait for A (delay 10)
        expect_out(4'd1, 32'hAAAA_0001);
        expect_out(4'd1, 32'hBBBB_0001);
        send(4'd1, 32'hAAAA_0001, 8'd10);
        send(4'd1, 32'hBBBB_0001, 8'd0);
        tick();
        tick();
        tick();
        check("same_id_b_held", 64'(out_valid_o), 64'd0);
        check("same_id_occ", 64'(occupancy_o), 64'd2);
        wait_drain();

        // Different IDs: B (ID 2, delay 0) overtakes A (ID 1, delay 10)
        expect_out(4'd2, 32'hBBBB_0002);
        expect_out(4'd1, 32'hAAAA_0011);
        send(4'd1, 32'hAAAA_0011, 8'd10);
        send(4'd2, 32'hBBBB_0002, 8'd0);
        check("diff_id_not_yet", 64'(out_valid_o), 64'd0);
        tick();
        check("diff_id_b_valid", 64'(out_valid_o), 64'd1);
        check("diff_id_b_id", 64'(out_id_o), 64'd2);
        wait_drain();

        // Fill all slots while stalled
        out_ready_i = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            expect_out(4'(i), 32'hF111_0000 + 32'(i));
            send(4'(i), 32'hF111_0000 + 32'(i), 8'd0);
        end
        check("full_in_ready", 64'(in_ready_o), 64'd0);
        check("full_occupancy", 64'(occupancy_o), 64'd8);
        out_ready_i = 1'b1;
        #1;
        check("full_ready_indep_of_out_ready", 64'(in_ready_o), 64'd0);
        tick();
        check("full_ready_after_release", 64'(in_ready_o), 64'd1);
        check("full_occ_after_release", 64'(occupancy_o), 64'd7);
        wait_drain();

        // Mid-operation reset with 5 entries held
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'(i), 32'hDEAD_0000 + 32'(i), 8'd3);
        end
        tick();
        tick();
        check("pre_rst_occ", 64'(occupancy_o), 64'd5);
        check("pre_rst_valid", 64'(out_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid_o), 64'd0);
        check("async_rst_occ", 64'(occupancy_o), 64'd0);
        check("async_rst_ready", 64'(in_ready_o), 64'd1);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
`ifdef SIMMEM_RESP_DELAY_STALL_COUNT_EN
        check("stall_cnt_after_rst", 64'(stall_cycles_o), 64'd0);
`endif

        // Stall 20 cycles while an older entry expires behind the presented one
        expect_out(4'd7, 32'h7777_0007);
        expect_out(4'd6, 32'h6666_0006);
        send(4'd6, 32'h6666_0006, 8'd8);
        send(4'd7, 32'h7777_0007, 8'd0);
        tick();
        check("stall_b_valid", 64'(out_valid_o), 64'd1);
        check("stall_b_id", 64'(out_id_o), 64'd7);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("stall_b_id_after", 64'(out_id_o), 64'd7);
        check("stall_b_data_after", 64'(out_data_o), 64'h7777_0007);
`ifdef SIMMEM_RESP_DELAY_STALL_COUNT_EN
        check("stall_cycles_20", 64'(stall_cycles_o), 64'd20);
`endif
        out_ready_i = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simmem_resp_delay_bank.md
Name: simmem_resp_delay_bank

Overview:
- Parametrised response-delay store for the simulated memory controller.
- Each response (read data beat or write response) arrives with a per-transaction delay and is held in one of NumSlots slots. It is released only when its countdown expires and no older entry with the same AXI ID is still held.
- Generalises the fixed-capacity rdata/wresp banks plus release-enable scheme. Capacity, ID width, payload width and delay width become parameters, and the block itself enforces same-ID ordering with oldest-first arbitration.
- One instance sits on the rdata channel and one on the wresp channel.

Parameters:
- NumSlots, 8, response slots held (2..64).
- IDWidth, 4, AXI ID width.
- DataWidth, 32, payload width excluding ID.
- DelayWidth, 8, width of the delay input and of each slot countdown.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid_i  in  1  response offered.
- in_ready_o  out  1  a free slot exists.
- in_id_i  in  IDWidth  response ID.
- in_data_i  in  DataWidth  response payload.
- in_delay_i  in  DelayWidth  cycles to hold beyond the minimum.
- out_valid_o  out  1  response presented.
- out_ready_i  in  1  downstream accepts.
- out_id_o  out  IDWidth  presented ID.
- out_data_o  out  DataWidth  presented payload.
- occupancy_o  out  $clog2(NumSlots+1)  slots currently valid.

Behaviour:
- Reset: all slots invalid, countdowns 0, age matrix 0, lock clear. Outputs: in_ready_o=1, out_valid_o=0, out_id_o=0, out_data_o=0, occupancy_o=0.
- A reset mid-operation discards every held entry immediately (asynchronously).
- in_ready_o depends on registered slot state only: it is 1 when any slot is invalid. It never depends on out_ready_i.
- Accept: on in_valid_i && in_ready_o, the lowest-index invalid slot stores ID, data and countdown=in_delay_i. It becomes valid at the next edge.
- Countdown: each edge, every valid slot with countdown>0 decrements by 1. Countdown saturates at 0 and never wraps.
- Eligible slot: valid, countdown==0, and no valid slot with the same ID that is older.
- Latency: delay d produces out_valid_o at the earliest d+1 cycles after the accept edge. Delay 0 gives 1 cycle.
- Age matrix: age[i][j]=1 means j is older than i. On allocating slot i, row i is set to the valid vector (excluding any slot freed on the same edge) and column i is cleared.
- Selection: the eligible slot that no other eligible slot is older than.
- Output stability (AXI):
  - Once out_valid_o rises, the selected slot is latched.
  - out_valid_o, out_id_o and out_data_o hold unchanged until out_valid_o && out_ready_i, even if an older entry becomes eligible meanwhile.
  - Outputs are driven from registers and the latched index, with no combinational path from in_* to out_*.
- Release: on handshake the slot is invalidated and the lock cleared. The next selection is presented no earlier than the following cycle, so one release per two cycles at most.
- Simultaneous accept and release: both occur. The freed slot is not reused on that same edge.
- Full (occupancy==NumSlots): in_ready_o=0. A release makes in_ready_o=1 the next cycle.
- Empty: out_valid_o=0.
- occupancy_o is updated on each edge: +1 on accept, −1 on release, net 0 when both occur.

Optional Feature:
- Macro: SIMMEM_RESP_DELAY_STALL_COUNT_EN.
- Defined: adds output port stall_cycles_o [15:0]. It increments each cycle with out_valid_o && !out_ready_i, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- simmem_pkg holds:
  - localparams RespDelayNumSlots, RespDelayWidth.
  - typedef resp_slot_t struct {id, data, countdown}.
  - typedef slot_idx_t.
- Sub-module simmem_oldest_select: input age matrix plus a request vector; output a one-hot grant and an index. It is used for both eligibility (same-ID older check) and oldest-first choice.

Test Plan:
- Single response, ID 3, delay 5, out_ready_i=1 -> out_valid_o rises exactly 6 cycles after the accept edge; out_id_o=3 with the matching data; occupancy_o returns 0.
- Same ID 1: A delay 10, then B delay 0 -> B is held until A is released; order A then B.
- Different IDs: A (ID 1) delay 10, then B (ID 2) delay 0 -> B is released first, 1 cycle after its accept.
- Fill 8 slots with out_ready_i=0 -> in_ready_o=0 and occupancy_o=8. With out_ready_i=1, in_ready_o=1 the cycle after the first release.
- Hold out_ready_i=0 for 20 cycles while an older entry expires -> out_* stay stable. With the macro defined, stall_cycles_o=20.
- Assert rst_ni=0 with 5 entries held -> out_valid_o=0 and occupancy_o=0 immediately. After reset releases, new traffic behaves normally.
